// File: rtl/vde_trail_ctrl.sv
// vde_trail_ctrl: initiator side of the VDE command interface.
// Owns the assignment trail and turns solver-core events (implied
// assignments, decision requests, backtracks and learned-clause bumps)
// into paced, registered VDE commands. The trail is a LIFO of
// {var, value, level}. A backtrack unwinds it one entry per cycle,
// issuing one clear per popped entry.
module vde_trail_ctrl #(
  parameter int MAX_VARS    = 256,
  parameter int TRAIL_DEPTH = 256,
  parameter int LEVEL_W     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               prop_valid,
  input  logic [31:0]                        prop_var,
  input  logic                               prop_value,
  input  logic                               decide_req,
  input  logic                               backtrack_valid,
  input  logic [LEVEL_W-1:0]                 backtrack_level,
  input  logic                               learn_valid,
  input  logic [3:0]                         learn_count,
  input  logic [7:0][31:0]                   learn_vars,
  output logic                               vde_request,
  input  logic                               vde_decision_valid,
  input  logic [31:0]                        vde_decision_var,
  input  logic                               vde_decision_phase,
  input  logic                               vde_all_assigned,
  output logic                               vde_assign_valid,
  output logic [31:0]                        vde_assign_var,
  output logic                               vde_assign_value,
  output logic                               vde_clear_valid,
  output logic [31:0]                        vde_clear_var,
  output logic [3:0]                         vde_bump_count,
  output logic [7:0][31:0]                   vde_bump_vars,
  output logic                               vde_decay,
  input  logic                               vde_pending_ops,
  output logic                               decision_out_valid,
  output logic [31:0]                        decision_out_var,
  output logic                               decision_out_phase,
  output logic                               sat_done,
  output logic                               bt_done,
  output logic [LEVEL_W-1:0]                 cur_level,
  output logic [$clog2(TRAIL_DEPTH+1)-1:0]   trail_count,
  output logic                               trail_overflow,
  output logic                               busy
);

  localparam int CNT_W  = $clog2(TRAIL_DEPTH + 1);
  localparam int ADDR_W = (TRAIL_DEPTH > 1) ? $clog2(TRAIL_DEPTH) : 1;

  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(TRAIL_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEVEL_W-1:0] LVL_ONE  = {{(LEVEL_W-1){1'b0}}, 1'b1};
  localparam logic [LEVEL_W-1:0] LVL_MAX  = {LEVEL_W{1'b1}};

  // The trail must be able to hold every variable at once.
  if (TRAIL_DEPTH < MAX_VARS) begin : g_cfg_bad
    $error("vde_trail_ctrl: TRAIL_DEPTH must be >= MAX_VARS");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEC_WAIT = 2'd1,
    ST_UNWIND   = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]        vid;
    logic               value;
    logic [LEVEL_W-1:0] level;
  } entry_t;

  // Trail storage; occupancy is tracked by count_r so the array needs no reset.
  entry_t trail_mem [TRAIL_DEPTH];

  state_t             state_r, state_nxt;
  logic [LEVEL_W-1:0] level_r, level_nxt;
  logic [LEVEL_W-1:0] bt_level_r, bt_level_nxt;
  logic [CNT_W-1:0]   count_r, count_nxt;
  logic               overflow_r, overflow_nxt;

  logic               assign_valid_r, assign_valid_nxt;
  logic [31:0]        assign_var_r, assign_var_nxt;
  logic               assign_value_r, assign_value_nxt;
  logic               clear_valid_r, clear_valid_nxt;
  logic [31:0]        clear_var_r, clear_var_nxt;
  logic               request_r, request_nxt;
  logic               dec_valid_r, dec_valid_nxt;
  logic [31:0]        dec_var_r, dec_var_nxt;
  logic               dec_phase_r, dec_phase_nxt;
  logic               sat_r, sat_nxt;
  logic               bt_done_r, bt_done_nxt;

  logic [3:0]         bump_count_r;
  logic [7:0][31:0]   bump_vars_r;
  logic               decay_arm_r;
  logic               decay_r;

  logic               push_req_s;
  logic               push_s;
  entry_t             push_entry_s;
  entry_t             top_s;
  logic [ADDR_W-1:0]  top_idx_s;
  logic [ADDR_W-1:0]  wr_idx_s;
  logic               full_s;
  logic               empty_s;
  logic [LEVEL_W-1:0] new_level_s;
  logic               learn_ok_s;

  // Index of the top-of-stack entry; wraps harmlessly when empty (guarded by empty_s).
  assign top_idx_s   = count_r[ADDR_W-1:0] - ADDR_ONE;
  assign wr_idx_s    = count_r[ADDR_W-1:0];
  assign top_s       = trail_mem[top_idx_s];
  assign full_s      = (count_r == DEPTH_C);
  assign empty_s     = (count_r == CNT_ZERO);
  assign new_level_s = (level_r == LVL_MAX) ? level_r : (level_r + LVL_ONE);
  assign learn_ok_s  = learn_valid && (learn_count != 4'd0) && (learn_count <= 4'd8);

  // State register for the command FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, trail push/pop and next values of all command pulses.
  always_comb begin
    state_nxt        = state_r;
    level_nxt        = level_r;
    bt_level_nxt     = bt_level_r;
    count_nxt        = count_r;
    overflow_nxt     = overflow_r;
    push_req_s       = 1'b0;
    push_s           = 1'b0;
    push_entry_s     = '0;
    assign_valid_nxt = 1'b0;
    assign_var_nxt   = 32'd0;
    assign_value_nxt = 1'b0;
    clear_valid_nxt  = 1'b0;
    clear_var_nxt    = 32'd0;
    request_nxt      = 1'b0;
    dec_valid_nxt    = 1'b0;
    dec_var_nxt      = 32'd0;
    dec_phase_nxt    = 1'b0;
    sat_nxt          = 1'b0;
    bt_done_nxt      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (backtrack_valid) begin
          if (backtrack_level >= level_r) begin
            bt_done_nxt = 1'b1;
          end else begin
            bt_level_nxt = backtrack_level;
            state_nxt    = ST_UNWIND;
          end
        end else if (prop_valid) begin
          push_req_s   = 1'b1;
          push_entry_s = '{vid: prop_var, value: prop_value, level: level_r};
        end else if (decide_req) begin
          request_nxt = 1'b1;
          state_nxt   = ST_DEC_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DEC_WAIT: begin
        if (vde_decision_valid) begin
          state_nxt = ST_IDLE;
          if (vde_all_assigned || (vde_decision_var == 32'd0)) begin
            sat_nxt = 1'b1;
          end else begin
            level_nxt     = new_level_s;
            push_req_s    = 1'b1;
            push_entry_s  = '{vid: vde_decision_var, value: vde_decision_phase,
                              level: new_level_s};
            dec_valid_nxt = 1'b1;
            dec_var_nxt   = vde_decision_var;
            dec_phase_nxt = vde_decision_phase;
          end
        end else begin
          state_nxt = ST_DEC_WAIT;
        end
      end
      ST_UNWIND: begin
        if (!empty_s && (top_s.level > bt_level_r)) begin
          count_nxt       = count_r - CNT_ONE;
          clear_valid_nxt = 1'b1;
          clear_var_nxt   = top_s.vid;
        end else begin
          level_nxt = bt_level_r;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!vde_pending_ops) begin
          bt_done_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A push into a full trail is dropped and leaves a sticky flag instead of an assign.
    if (push_req_s) begin
      if (full_s) begin
        overflow_nxt = 1'b1;
      end else begin
        push_s           = 1'b1;
        count_nxt        = count_r + CNT_ONE;
        assign_valid_nxt = 1'b1;
        assign_var_nxt   = push_entry_s.vid;
        assign_value_nxt = push_entry_s.value;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Trail write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      trail_mem[wr_idx_s] <= push_entry_s;
    end
  end

  // Registered level, trail occupancy and all command/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r        <= '0;
      bt_level_r     <= '0;
      count_r        <= '0;
      overflow_r     <= 1'b0;
      assign_valid_r <= 1'b0;
      assign_var_r   <= 32'd0;
      assign_value_r <= 1'b0;
      clear_valid_r  <= 1'b0;
      clear_var_r    <= 32'd0;
      request_r      <= 1'b0;
      dec_valid_r    <= 1'b0;
      dec_var_r      <= 32'd0;
      dec_phase_r    <= 1'b0;
      sat_r          <= 1'b0;
      bt_done_r      <= 1'b0;
    end else begin
      level_r        <= level_nxt;
      bt_level_r     <= bt_level_nxt;
      count_r        <= count_nxt;
      overflow_r     <= overflow_nxt;
      assign_valid_r <= assign_valid_nxt;
      assign_var_r   <= assign_var_nxt;
      assign_value_r <= assign_value_nxt;
      clear_valid_r  <= clear_valid_nxt;
      clear_var_r    <= clear_var_nxt;
      request_r      <= request_nxt;
      dec_valid_r    <= dec_valid_nxt;
      dec_var_r      <= dec_var_nxt;
      dec_phase_r    <= dec_phase_nxt;
      sat_r          <= sat_nxt;
      bt_done_r      <= bt_done_nxt;
    end
  end

  // Learn path: bump next cycle, decay the cycle after; runs regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bump_count_r <= 4'd0;
      bump_vars_r  <= '0;
      decay_arm_r  <= 1'b0;
      decay_r      <= 1'b0;
    end else begin
      bump_count_r <= learn_ok_s ? learn_count : 4'd0;
      bump_vars_r  <= learn_ok_s ? learn_vars : '0;
      decay_arm_r  <= learn_ok_s;
      decay_r      <= decay_arm_r;
    end
  end

  assign vde_request        = request_r;
  assign vde_assign_valid   = assign_valid_r;
  assign vde_assign_var     = assign_var_r;
  assign vde_assign_value   = assign_value_r;
  assign vde_clear_valid    = clear_valid_r;
  assign vde_clear_var      = clear_var_r;
  assign vde_bump_count     = bump_count_r;
  assign vde_bump_vars      = bump_vars_r;
  assign vde_decay          = decay_r;
  assign decision_out_valid = dec_valid_r;
  assign decision_out_var   = dec_var_r;
  assign decision_out_phase = dec_phase_r;
  assign sat_done           = sat_r;
  assign bt_done            = bt_done_r;
  assign cur_level          = level_r;
  assign trail_count        = count_r;
  assign trail_overflow     = overflow_r;
  assign busy               = (state_r != ST_IDLE);

endmodule
